// File: rtl/mem_rd_arbiter_if.sv
// Signal bundle for the shared memory read channel: I-cache, D-cache and memory sides.
// The master modport is the arbiter's view of the bundle. The slave modport is the view from the caches and memory.
interface mem_rd_arbiter_if;
    logic        from_ic_rd_req_valid;
    logic [31:0] from_ic_rd_req_addr;
    logic        to_ic_rd_req_ready;
    logic        to_ic_rd_rsp_valid;
    logic [31:0] to_ic_rd_rsp_data;
    logic        to_ic_rd_rsp_last;
    logic        from_ic_rd_rsp_ready;

    logic        from_dc_rd_req_valid;
    logic [31:0] from_dc_rd_req_addr;
    logic        to_dc_rd_req_ready;
    logic        to_dc_rd_rsp_valid;
    logic [31:0] to_dc_rd_rsp_data;
    logic        to_dc_rd_rsp_last;
    logic        from_dc_rd_rsp_ready;

    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready;
    logic        from_mem_rd_rsp_valid;
    logic [31:0] from_mem_rd_rsp_data;
    logic        from_mem_rd_rsp_last;
    logic        to_mem_rd_rsp_ready;

    modport master (
        input  from_ic_rd_req_valid, from_ic_rd_req_addr, from_ic_rd_rsp_ready,
        input  from_dc_rd_req_valid, from_dc_rd_req_addr, from_dc_rd_rsp_ready,
        input  from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
        input  from_mem_rd_rsp_last,
        output to_ic_rd_req_ready, to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_ic_rd_rsp_last,
        output to_dc_rd_req_ready, to_dc_rd_rsp_valid, to_dc_rd_rsp_data, to_dc_rd_rsp_last,
        output to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
    );

    modport slave (
        output from_ic_rd_req_valid, from_ic_rd_req_addr, from_ic_rd_rsp_ready,
        output from_dc_rd_req_valid, from_dc_rd_req_addr, from_dc_rd_rsp_ready,
        output from_mem_rd_req_ready, from_mem_rd_rsp_valid, from_mem_rd_rsp_data,
        output from_mem_rd_rsp_last,
        input  to_ic_rd_req_ready, to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_ic_rd_rsp_last,
        input  to_dc_rd_req_ready, to_dc_rd_rsp_valid, to_dc_rd_rsp_data, to_dc_rd_rsp_last,
        input  to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter that shares one burst memory read channel between the I-cache and the D-cache.
// One request is in flight at a time. Response beats pass through to the granted cache until the last beat.
module mem_rd_arbiter (
    input  logic clk,
    input  logic rst,
    mem_rd_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RSP  = 3'b100
    } state_t;

    state_t      state;
    logic        grant;
    logic        prio;
    logic [31:0] addr_q;
    logic        req_valid_q;

    logic ic_win, dc_win;
    logic in_idle, in_rsp;
    logic to_ic, to_dc;
    logic sel_rsp_ready;
    logic beat_done;

    assign ic_win = bus.from_ic_rd_req_valid & (~bus.from_dc_rd_req_valid | ~prio);
    assign dc_win = bus.from_dc_rd_req_valid & (~bus.from_ic_rd_req_valid |  prio);

    // The combinational outputs are masked while rst is high. An aborted burst then exposes nothing to the caches in the reset cycle.
    assign in_idle = (state == IDLE) & ~rst;
    assign in_rsp  = (state == RSP)  & ~rst;
    assign to_ic   = in_rsp & ~grant;
    assign to_dc   = in_rsp &  grant;

    assign sel_rsp_ready = grant ? bus.from_dc_rd_rsp_ready : bus.from_ic_rd_rsp_ready;
    assign beat_done     = bus.from_mem_rd_rsp_valid & sel_rsp_ready & bus.from_mem_rd_rsp_last;

    assign bus.to_ic_rd_req_ready = in_idle & ic_win;
    assign bus.to_dc_rd_req_ready = in_idle & dc_win;

    assign bus.to_ic_rd_rsp_valid = to_ic & bus.from_mem_rd_rsp_valid;
    assign bus.to_ic_rd_rsp_data  = to_ic ? bus.from_mem_rd_rsp_data : '0;
    assign bus.to_ic_rd_rsp_last  = to_ic & bus.from_mem_rd_rsp_last;
    assign bus.to_dc_rd_rsp_valid = to_dc & bus.from_mem_rd_rsp_valid;
    assign bus.to_dc_rd_rsp_data  = to_dc ? bus.from_mem_rd_rsp_data : '0;
    assign bus.to_dc_rd_rsp_last  = to_dc & bus.from_mem_rd_rsp_last;

    // Holding ready high during reset drains stale beats from memory.
    assign bus.to_mem_rd_rsp_ready = rst | (in_rsp & sel_rsp_ready);
    assign bus.to_mem_rd_req_valid = req_valid_q & ~rst;
    assign bus.to_mem_rd_req_addr  = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            prio        <= 1'b0;
            addr_q      <= '0;
            req_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ic_win | dc_win) begin
                        grant       <= dc_win & ~ic_win;
                        addr_q      <= ic_win ? bus.from_ic_rd_req_addr : bus.from_dc_rd_req_addr;
                        req_valid_q <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus.from_mem_rd_req_ready) begin
                        req_valid_q <= 1'b0;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (beat_done) begin
                        prio  <= ~grant;
                        state <= IDLE;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
